// File: rtl/flxx_wb_regfile.sv
// Writeback queue that commits decode/execute results into the register and memory-mapped banks.
// Optional macro FLXX_WB_FORWARD_EN: a non-jump result pushed into an empty, idle queue commits directly.
module flxx_wb_regfile #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int NREG  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [5:0]                 wb_outreg,
  input  logic [XLEN-1:0]            wb_outval,
  input  logic                       flush,
  output logic [NREG-1:0][XLEN-1:0]  regarray,
  output logic [NREG-1:0][XLEN-1:0]  mem_regarray,
  output logic                       jmp_valid,
  output logic [XLEN-1:0]            jmp_target,
  output logic                       wb_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t          state;
  logic [5:0]      q_reg [DEPTH];
  logic [XLEN-1:0] q_val [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr, count;
  logic            empty, full, push, fwd, enq, commit, jmp_commit, wr_en;
  logic [5:0]      head_reg;
  logic [4:0]      wr_reg;
  logic [XLEN-1:0] head_val, wr_val;

  always_comb begin
    count      = wr_ptr - rd_ptr;
    empty      = (count == '0);
    full       = (count == FULL_CNT);
    wb_ready   = rst_n && !full && (state == IDLE) && !flush;
    wb_busy    = !empty || (state != IDLE);
    push       = wb_valid && wb_ready;
    head_reg   = q_reg[rd_ptr[AW-1:0]];
    head_val   = q_val[rd_ptr[AW-1:0]];
    commit     = (state == IDLE) && !empty && !flush;
    jmp_commit = commit && head_reg[5];
`ifdef FLXX_WB_FORWARD_EN
    fwd        = push && empty && !wb_outreg[5];
`else
    fwd        = 1'b0;
`endif
    // A result arriving on the same edge as a jump commit is younger than the jump and is squashed.
    enq        = push && !fwd && !jmp_commit;
    wr_en      = fwd || (commit && !head_reg[5]);
    wr_reg     = fwd ? wb_outreg[4:0] : head_reg[4:0];
    wr_val     = fwd ? wb_outval : head_val;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_reg[wr_ptr[AW-1:0]] <= wb_outreg;
      q_val[wr_ptr[AW-1:0]] <= wb_outval;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      jmp_valid    <= 1'b0;
      jmp_target   <= '0;
      regarray     <= '0;
      mem_regarray <= '0;
    end else begin
      jmp_valid <= jmp_commit;
      if (jmp_commit) jmp_target <= head_val;

      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (flush || jmp_commit) rd_ptr <= wr_ptr;
      else if (commit)         rd_ptr <= rd_ptr + 1'b1;

      case (state)
        IDLE:    if (jmp_commit) state <= REDIRECT;
        default: state <= IDLE;
      endcase

      // Register 0 of the architectural bank is hard-wired to zero.
      if (wr_en) begin
        if (wr_reg[4])                mem_regarray[wr_reg[3:0]] <= wr_val;
        else if (wr_reg[3:0] != 4'd0) regarray[wr_reg[3:0]]     <= wr_val;
      end
    end
  end

endmodule
